alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 112 +++++++++++
 tb/tb_alu_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage elastic Hack-style ALU (operand preset stage, then result/flag stage).
// Optional unsigned carry / signed overflow flags are built when ALU_PIPE_CARRY_EN is defined.
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cf,
    output logic             vf
);

    logic             s1_valid_q, s2_valid_q;
    logic             s1_adv, s2_adv, accept, s2_load;
    logic [WIDTH-1:0] xp_d, yp_d, xp_q, yp_q;
    logic             f_q, no_q;
    logic [WIDTH-1:0] sum, res_d, out_q;
    logic             zr_q, ng_q;

    // Ready depends only on pipeline occupancy and out_ready, never on in_valid.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;
    assign s2_load  = s2_adv && s1_valid_q;

    always_comb begin
        xp_d = ctrl[5] ? '0 : x;
        if (ctrl[4]) xp_d = ~xp_d;
        yp_d = ctrl[3] ? '0 : y;
        if (ctrl[2]) yp_d = ~yp_d;
    end

`ifdef ALU_PIPE_CARRY_EN
    logic [WIDTH:0] sum_ext;
    logic           cf_d, vf_d, cf_q, vf_q;

    assign sum_ext = {1'b0, xp_q} + {1'b0, yp_q};
    assign sum     = sum_ext[WIDTH-1:0];

    // Flags describe the addition itself, before the optional output inversion.
    always_comb begin
        cf_d = f_q & sum_ext[WIDTH];
        vf_d = f_q & (xp_q[WIDTH-1] == yp_q[WIDTH-1]) & (sum[WIDTH-1] != xp_q[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cf_q <= 1'b0;
            vf_q <= 1'b0;
        end else if (s2_load) begin
            cf_q <= cf_d;
            vf_q <= vf_d;
        end
    end

    assign cf = cf_q;
    assign vf = vf_q;
`else
    assign sum = xp_q + yp_q;
    assign cf  = 1'b0;
    assign vf  = 1'b0;
`endif

    always_comb begin
        res_d = f_q ? sum : (xp_q & yp_q);
        if (no_q) res_d = ~res_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            xp_q       <= '0;
            yp_q       <= '0;
            f_q        <= 1'b0;
            no_q       <= 1'b0;
            out_q      <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (accept) begin
                xp_q <= xp_d;
                yp_q <= yp_d;
                f_q  <= ctrl[1];
                no_q <= ctrl[0];
            end
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s2_load) begin
                out_q <= res_d;
                zr_q  <= (res_d == '0);
                ng_q  <= res_d[WIDTH-1];
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH = 16): vector table plus stall, throughput
// and reset sequences. Expected cf/vf follow whether ALU_PIPE_CARRY_EN is defined.
module tb_alu_pipe;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctrl;
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        cf;   // value with carry flags enabled
        logic        vf;
    } vec_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] x, y, out;
    logic [5:0]  ctrl;
    logic        zr, ng, cf, vf;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .ctrl     (ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .zr       (zr),
        .ng       (ng),
        .cf       (cf),
        .vf       (vf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_flag(input logic v);
`ifdef ALU_PIPE_CARRY_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic set_in(input logic v, input vec_t t);
        in_valid = v;
        x        = t.x;
        y        = t.y;
        ctrl     = t.ctrl;
    endtask

    // One isolated beat: accepted at the first edge, visible after the second.
    task automatic run_vec(input vec_t t, input int i);
        @(posedge clk); #1;
        set_in(1'b1, t);
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d latency_early", i), {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
        chk($sformatf("v%0d out", i), {16'b0, out}, {16'b0, t.out});
        chk($sformatf("v%0d zr_ng", i), {30'b0, zr, ng}, {30'b0, t.zr, t.ng});
        chk($sformatf("v%0d cf_vf", i), {30'b0, cf, vf},
            {30'b0, exp_flag(t.cf), exp_flag(t.vf)});
    endtask

    // Four beats offered back-to-back; optionally out_ready is held low for 3 cycles.
    task automatic run_burst(input vec_t b[4], input bit stall);
        int          idx = 0, got = 0, first = -1, last = -1;
        logic        acc;
        logic [19:0] held = '0;
        @(posedge clk); #1;
        out_ready = !stall;
        set_in(1'b1, b[0]);
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (stall && c == 2) begin
                chk("stall in_ready_low", {31'b0, in_ready}, 32'd0);
                chk("stall accepted", idx, 2);
                held = {out, zr, ng, cf, vf};
            end
            if (stall && (c == 3 || c == 4)) begin
                chk($sformatf("stall hold c%0d", c), {12'b0, out, zr, ng, cf, vf}, {12'b0, held});
                chk($sformatf("stall valid c%0d", c), {30'b0, out_valid, in_ready}, 32'd2);
            end
            if (!stall && idx < 4)
                chk($sformatf("flow in_ready c%0d", c), {31'b0, in_ready}, 32'd1);
            if (out_valid && out_ready) begin
                chk($sformatf("burst%0d out%0d", stall, got), {16'b0, out}, {16'b0, b[got].out});
                chk($sformatf("burst%0d flags%0d", stall, got), {30'b0, zr, ng},
                    {30'b0, b[got].zr, b[got].ng});
                if (first < 0) first = c;
                last = c;
                got++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 4) set_in(1'b1, b[idx]);
            else in_valid = 1'b0;
            out_ready = !stall || (c + 1 >= 5);
        end
        chk($sformatf("burst%0d count", stall), got, 4);
        if (!stall) chk("flow no_bubble", last - first, 3);
    endtask

    vec_t tbl[9];
    vec_t bst[4];
    int   nv;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = '0;
        y = '0;
        ctrl = '0;

        //        x        y        ctrl       out      zr ng cf vf
        tbl[0] = '{16'h0011, 16'h0003, 6'b000010, 16'h0014, 0, 0, 0, 0};
        tbl[1] = '{16'h1234, 16'h5678, 6'b101010, 16'h0000, 1, 0, 0, 0};
        tbl[2] = '{16'h1234, 16'h5678, 6'b111111, 16'h0001, 0, 0, 1, 0};
        tbl[3] = '{16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 0, 1, 0, 0};
        tbl[4] = '{16'h0005, 16'h0007, 6'b010011, 16'hFFFE, 0, 1, 1, 0};
        tbl[5] = '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 0, 1, 0, 1};
        tbl[6] = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1, 0, 1, 0};
        tbl[7] = '{16'h00F0, 16'h0FF0, 6'b000000, 16'h00F0, 0, 0, 0, 0};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 6'b000001, 16'h0000, 1, 0, 0, 0};
        nv = 9;

        bst[0] = '{16'h0001, 16'h0002, 6'b000010, 16'h0003, 0, 0, 0, 0};
        bst[1] = '{16'h00FF, 16'h0F0F, 6'b000000, 16'h000F, 0, 0, 0, 0};
        bst[2] = '{16'h0005, 16'h0007, 6'b010011, 16'hFFFE, 0, 1, 1, 0};
        bst[3] = '{16'h1234, 16'h0000, 6'b001100, 16'h1234, 0, 0, 0, 0};

        #12;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset outputs", {12'b0, out, zr, ng, cf, vf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < nv; i++) run_vec(tbl[i], i);

        run_burst(bst, 1'b1);
        run_burst(bst, 1'b0);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(1'b1, bst[0]);
        @(posedge clk); #1;
        set_in(1'b1, bst[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("inflight out_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", {31'b0, out_valid}, 32'd0);
        chk("midreset outputs", {12'b0, out, zr, ng, cf, vf}, 32'd0);
        chk("midreset in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("after_reset no_output", seen, 0);
        end
        run_vec(tbl[0], 100);
        run_vec(tbl[5], 105);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
